seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
- Receive end of the seven-segment display interface: samples a multiplexed display bus (segment bits plus active-low digit anodes) and recovers the BCD value of each digit position.
- The bus is driven by our digit encoders and scan logic, or by an external board in loopback.
- Publishes a complete frame of digits, with decimal-point and error flags, once every position has been captured.
- Used for loopback self-test of the display path and for on-chip checking in lab benches.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digit positions (anode lines).
- STABLE_CYCLES, 4: consecutive unchanged synchronized samples required before a digit is captured; minimum 1.
- SYNC_STAGES, 2: input synchronizer depth; minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- seg_in  input  8  segment bus, active-low; bit0=a … bit6=g, bit7=dp.
- an_in  input  NUM_DIGITS  digit select, active-low; exactly one low means a valid slot, and bit k low selects digit k.
- digits_out  output  4*NUM_DIGITS  recovered digits; digit k is at [4k+3:4k].
- dp_out  output  NUM_DIGITS  decimal point lit, per digit (1 = lit).
- err_out  output  NUM_DIGITS  per digit: segment pattern was not 0–9.
- frame_valid  output  1  one-cycle pulse when the frame outputs update.
- frame_err  output  1  OR of err_out for the frame just published; held until the next frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While reset is low, every flop clears immediately: digits_out=0, dp_out=0, err_out=0, frame_valid=0, frame_err=0, seen mask=0, shadow registers=0, state=IDLE, counter=0.
- Input synchronization: {an_in, seg_in} pass through SYNC_STAGES flops as one vector. Call the result s; call the previous cycle's value s_prev.
- Decode table, on seg[6:0] active-low:
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10.
  - Any other pattern gives digit 4'hF and err=1.
  - dp = ~seg[7]; dp never affects the digit decode.
- State machine, evaluated on s, with a counter of width $clog2(STABLE_CYCLES+1):
  - IDLE: s.an not one-hot-low (all high, or more than one low). Counter held at 0. When s.an becomes valid, go to SETTLE with cnt=0.
  - SETTLE:
    - If s != s_prev: cnt=0.
    - Else: cnt+1.
    - When cnt==STABLE_CYCLES-1 and s==s_prev: capture and go to HOLD.
    - If s.an becomes invalid: go to IDLE.
  - HOLD: no recapture while s is unchanged. When s != s_prev, go to SETTLE with cnt=0 if s.an is valid, otherwise go to IDLE.
- Capture for slot k (from s.an): write the shadow digit, dp and err for k, and set seen[k].
  - A re-capture of a slot already seen this frame overwrites its shadow; latest value wins.
- Frame publish:
  - On the cycle after the capture that makes seen all-ones, copy the shadows to digits_out, dp_out and err_out.
  - Set frame_err to the OR of the shadow err bits, pulse frame_valid for 1 cycle, and clear seen.
  - Outputs hold between publishes.
  - A capture in the publish cycle belongs to the next frame.
- Latency: pin change → s is SYNC_STAGES cycles. s becoming stable → capture is STABLE_CYCLES cycles. Final capture → frame_valid is 1 cycle.
- Glitch filter: a pattern held for fewer than STABLE_CYCLES synchronized cycles is never captured.
- Reset mid-frame: any partial seen mask is discarded. The first frame after reset requires every slot again.

Decomposition:
- Shared package seven_seg_pkg holds:
  - the SEG_0..SEG_9 active-low 7-bit constants;
  - SEG_DP_BIT=7;
  - DIGIT_INVALID=4'hF;
  - the decoder state enum (IDLE, SETTLE, HOLD).
- The same constants are reused by the digit encoder, so encoder and decoder share one table.
- One natural combinational sub-module, seven_seg_pattern_decode: input 7-bit pattern, outputs 4-bit digit and err.
- The synchronizer, state machine and frame logic stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-scan after two slots have been captured, then release and drive a full 4-slot scan. Required: all outputs are 0 during reset, and exactly one frame_valid occurs after all 4 new slots are captured.
- Basic frame: scan an=4'b1110/1101/1011/0111 with seg 8'hC0, 8'hF9, 8'hA4, 8'hB0, each held 10 cycles. Required: one frame_valid; digits_out=16'h3210; dp_out=0; err_out=0; frame_err=0.
- Timing: hold each slot for exactly STABLE_CYCLES cycles after synchronization. Required: each slot is captured; frame_valid rises SYNC_STAGES+STABLE_CYCLES+1 cycles after the last slot's pins are set. A slot held STABLE_CYCLES-1 cycles gets no capture and no frame.
- Glitch and invalid select:
  - Insert a 2-cycle seg=8'h00 glitch inside slot 1's value 8'h99. Required: digit 1 reads 4.
  - Drive an=4'b1100 or 4'b1111 for 20 cycles. Required: no capture, seen mask unchanged.
- Error and dp: send slot 2 with seg=8'h7F (dp lit, all other segments off). Required: digit 2=4'hF, err_out[2]=1, dp_out[2]=1, frame_err=1. On the following clean frame, frame_err returns to 0.
- Overwrite: scan slots 0, 0, 1, 2, 3, with slot 0 first as 8'h80 (8) then 8'h90 (9). Required: digits_out[3:0]=9, and frame_valid pulses once.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Constants shared by the seven-segment encoder and decoder.
//               Active-low segment patterns for 0-9 (bit0=a .. bit6=g), the
//               decimal-point bit position, the invalid-digit code and the
//               scan decoder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam int         SEG_DP_BIT    = 7;
    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/seven_seg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pattern_decode
// Description : Maps an active-low 7-segment pattern back to its BCD digit.
//               Patterns outside 0-9 return DIGIT_INVALID with err set.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       err
);

    // Reverse lookup of the shared segment table
    always_comb begin
        digit = DIGIT_INVALID;
        err   = 1'b1;
        case (pattern)
            SEG_0:   begin digit = 4'd0; err = 1'b0; end
            SEG_1:   begin digit = 4'd1; err = 1'b0; end
            SEG_2:   begin digit = 4'd2; err = 1'b0; end
            SEG_3:   begin digit = 4'd3; err = 1'b0; end
            SEG_4:   begin digit = 4'd4; err = 1'b0; end
            SEG_5:   begin digit = 4'd5; err = 1'b0; end
            SEG_6:   begin digit = 4'd6; err = 1'b0; end
            SEG_7:   begin digit = 4'd7; err = 1'b0; end
            SEG_8:   begin digit = 4'd8; err = 1'b0; end
            SEG_9:   begin digit = 4'd9; err = 1'b0; end
            default: begin digit = DIGIT_INVALID; err = 1'b1; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_decoder
// Description : Samples a multiplexed seven-segment bus (active-low segments
//               and anodes), waits for each slot to settle, captures its
//               digit/dp/error into shadow registers and publishes a full
//               frame once every digit position has been seen.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int               W          = NUM_DIGITS + 8;
    localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][W-1:0] r_sync;
    logic [W-1:0]                  r_s_prev;
    dec_state_t                    r_state;
    dec_state_t                    w_state_next;
    logic [CNT_W-1:0]              r_cnt;
    logic [CNT_W-1:0]              w_cnt_next;
    logic                          w_capture;

    logic [4*NUM_DIGITS-1:0]       r_sh_digits;
    logic [NUM_DIGITS-1:0]         r_sh_dp;
    logic [NUM_DIGITS-1:0]         r_sh_err;
    logic [NUM_DIGITS-1:0]         r_seen;
    logic                          r_publish;

    logic [4*NUM_DIGITS-1:0]       r_digits;
    logic [NUM_DIGITS-1:0]         r_dp;
    logic [NUM_DIGITS-1:0]         r_err;
    logic                          r_frame_valid;
    logic                          r_frame_err;

    // Synchronized view of the bus: s and its fields
    logic [W-1:0]            w_s;
    logic [NUM_DIGITS-1:0]   w_s_an;
    logic [7:0]              w_s_seg;
    logic                    w_an_valid;
    logic                    w_changed;
    logic [NUM_DIGITS-1:0]   w_slot;
    logic [3:0]              w_dec_digit;
    logic                    w_dec_err;
    logic                    w_dec_dp;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    logic                    w_publish_next;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_s_an     = w_s[W-1:8];
    assign w_s_seg    = w_s[7:0];
    assign w_an_valid = $onehot(~w_s_an);
    assign w_changed  = (w_s != r_s_prev);
    assign w_slot     = ~w_s_an;
    assign w_dec_dp   = ~w_s_seg[SEG_DP_BIT];

    seven_seg_pattern_decode u_decode (
        .pattern (w_s_seg[6:0]),
        .digit   (w_dec_digit),
        .err     (w_dec_err)
    );

    // Anodes and segments travel through the synchronizer as one vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_s_prev <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], {an_in, seg_in}};
            r_s_prev <= w_s;
        end
    end

    // Settle tracking: the cycle a new pattern first appears counts as its
    // first stable sample, so capture fires after STABLE_CYCLES samples.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_an_valid) begin
                    if (C_CNT_LAST == '0) begin
                        w_capture    = 1'b1;
                        w_state_next = HOLD;
                    end else begin
                        w_state_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!w_an_valid) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_changed ? '0 : r_cnt + 1'b1;
                    if (w_cnt_next == C_CNT_LAST) begin
                        w_capture    = 1'b1;
                        w_state_next = HOLD;
                        w_cnt_next   = '0;
                    end
                end
            end
            HOLD: begin
                if (w_changed) begin
                    w_cnt_next = '0;
                    if (!w_an_valid) begin
                        w_state_next = IDLE;
                    end else if (C_CNT_LAST == '0) begin
                        w_capture    = 1'b1;
                        w_state_next = HOLD;
                    end else begin
                        w_state_next = SETTLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State and settle counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A publish cycle starts a fresh frame, so a capture landing in it
    // counts toward the next frame rather than being dropped.
    always_comb begin
        w_seen_next    = (r_publish ? '0 : r_seen) | (w_capture ? w_slot : '0);
        w_publish_next = w_capture && (&w_seen_next);
    end

    // Shadow capture for the selected slot; later captures overwrite
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_err    <= '0;
        end else if (w_capture) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_slot[k]) begin
                    r_sh_digits[4*k +: 4] <= w_dec_digit;
                    r_sh_dp[k]            <= w_dec_dp;
                    r_sh_err[k]           <= w_dec_err;
                end
            end
        end
    end

    // Frame bookkeeping and publication of the shadow set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen        <= '0;
            r_publish     <= 1'b0;
            r_digits      <= '0;
            r_dp          <= '0;
            r_err         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_seen        <= w_seen_next;
            r_publish     <= w_publish_next;
            r_frame_valid <= r_publish;
            if (r_publish) begin
                r_digits    <= r_sh_digits;
                r_dp        <= r_sh_dp;
                r_err       <= r_sh_err;
                r_frame_err <= |r_sh_err;
            end
        end
    end

    assign digits_out  = r_digits;
    assign dp_out      = r_dp;
    assign err_out     = r_err;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_decoder
// Description : Self-checking bench for seven_seg_scan_decoder. A run-length
//               reference model of the synchronized bus predicts every output
//               each cycle; directed scans pin literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seven_seg_scan_decoder;

    localparam int NUM    = 4;
    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  seg_in = 8'hFF;
    logic [3:0]  an_in  = 4'hF;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic [3:0]  err_out;
    logic        frame_valid;
    logic        frame_err;

    int total    = 0;
    int bad      = 0;
    int n_frames = 0;

    always #5 clk = ~clk;

    seven_seg_scan_decoder #(
        .NUM_DIGITS    (NUM),
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits_out  (digits_out),
        .dp_out      (dp_out),
        .err_out     (err_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    // ---------------- reference model ----------------
    logic [6:0]  tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [11:0] m_sync [SYNC];
    logic [11:0] m_sprev;
    int          m_run;
    logic [15:0] sh_dig, m_dig;
    logic [3:0]  sh_dp, sh_err, m_dp, m_err, m_seen;
    logic        m_pend, m_fv, m_ferr;

    function automatic logic [4:0] mdec(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (tbl[i] == p) return {1'b0, 4'(i)};
        return 5'h1F;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
        m_sprev = '0; m_run = 1;
        sh_dig = '0; sh_dp = '0; sh_err = '0; m_seen = '0; m_pend = 1'b0;
        m_dig = '0; m_dp = '0; m_err = '0; m_fv = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic model_step();
        logic [11:0] s;
        logic [3:0]  an_s, base;
        logic [4:0]  d;
        logic        cap;
        s = m_sync[SYNC-1];
        if (s == m_sprev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else              m_run = 1;
        an_s = s[11:8];
        // a slot is taken exactly when its pattern reaches STABLE samples
        cap  = ($countones(~an_s) == 1) && (m_run == STABLE);
        base = m_pend ? 4'h0 : m_seen;
        if (m_pend) begin
            m_dig = sh_dig; m_dp = sh_dp; m_err = sh_err; m_ferr = |sh_err;
        end
        m_fv = m_pend;
        if (cap) begin
            for (int k = 0; k < NUM; k++) begin
                if (!an_s[k]) begin
                    d = mdec(s[6:0]);
                    sh_dig[4*k +: 4] = d[3:0];
                    sh_err[k] = d[4];
                    sh_dp[k]  = ~s[7];
                    base[k]   = 1'b1;
                end
            end
        end
        m_pend = cap && (base == 4'hF);
        m_seen = base;
        for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = {an_in, seg_in};
        m_sprev = s;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            total++;
            if ({digits_out, dp_out, err_out, frame_valid, frame_err} !==
                {m_dig, m_dp, m_err, m_fv, m_ferr}) begin
                bad++;
                $display("FAIL model t=%0t got dig=%h dp=%b err=%b fv=%b ferr=%b want dig=%h dp=%b err=%b fv=%b ferr=%b",
                         $time, digits_out, dp_out, err_out, frame_valid, frame_err,
                         m_dig, m_dp, m_err, m_fv, m_ferr);
            end
        end
    end

    always @(posedge clk) if (frame_valid) n_frames <= n_frames + 1;

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        drive(4'hF, 8'hFF, n);
    endtask

    task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3, input int n);
        drive(4'hE, s0, n);
        drive(4'hD, s1, n);
        drive(4'hB, s2, n);
        drive(4'h7, s3, n);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int f0;
        int lat;
        logic [3:0] ran;
        logic [7:0] rseg;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_digits", 32'(digits_out), 32'h0);
        check("reset_flags", 32'({dp_out, err_out, frame_valid, frame_err}), 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // basic frame
        f0 = n_frames;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 10);
        blank(10);
        check("basic_frames", 32'(n_frames - f0), 32'd1);
        check("basic_digits", 32'(digits_out), 32'h3210);
        check("basic_dp_err", 32'({dp_out, err_out, frame_err}), 32'h0);

        // minimum hold per slot and publish latency
        f0 = n_frames;
        drive(4'hE, 8'h92, STABLE);
        drive(4'hD, 8'h82, STABLE);
        drive(4'hB, 8'hF8, STABLE);
        an_in = 4'h7; seg_in = 8'h80;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == STABLE) begin an_in = 4'hF; seg_in = 8'hFF; end
            if (frame_valid && lat == 0) lat = i;
        end
        check("timing_latency", 32'(lat), 32'(SYNC + STABLE + 1));
        check("timing_frames", 32'(n_frames - f0), 32'd1);
        check("timing_digits", 32'(digits_out), 32'h8765);

        // slot held one cycle short, then invalid selects
        f0 = n_frames;
        drive(4'hE, 8'hF9, STABLE);
        drive(4'hD, 8'hA4, STABLE);
        drive(4'hB, 8'hB0, STABLE);
        drive(4'h7, 8'h99, STABLE - 1);
        blank(20);
        check("short_no_frame", 32'(n_frames - f0), 32'd0);
        drive(4'b1100, 8'hC0, 20);
        drive(4'b1111, 8'hC0, 20);
        check("invalid_no_frame", 32'(n_frames - f0), 32'd0);
        drive(4'h7, 8'h90, 10);
        blank(10);
        check("resume_frames", 32'(n_frames - f0), 32'd1);
        check("resume_digits", 32'(digits_out), 32'h9321);

        // short glitch at the tail of slot 1
        drive(4'hE, 8'hC0, 10);
        drive(4'hD, 8'h99, 6);
        drive(4'hD, 8'h00, 2);
        drive(4'hD, 8'h99, 2);
        drive(4'hB, 8'hA4, 10);
        drive(4'h7, 8'hB0, 10);
        blank(10);
        check("glitch_digits", 32'(digits_out), 32'h3240);
        check("glitch_dp", 32'(dp_out), 32'h0);

        // error pattern with dp lit, then a clean frame
        f0 = n_frames;
        scan(8'hC0, 8'hF9, 8'h7F, 8'hA4, 10);
        blank(10);
        check("err_frames", 32'(n_frames - f0), 32'd1);
        check("err_digits", 32'(digits_out), 32'h2F10);
        check("err_flags", 32'({err_out, dp_out, frame_err}), 32'({4'b0100, 4'b0100, 1'b1}));
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 10);
        blank(10);
        check("clean_flags", 32'({err_out, dp_out, frame_err}), 32'h0);

        // overwrite of slot 0 within one frame
        f0 = n_frames;
        drive(4'hE, 8'h80, 10);
        drive(4'hE, 8'h90, 10);
        drive(4'hD, 8'hF9, 10);
        drive(4'hB, 8'hA4, 10);
        drive(4'h7, 8'hB0, 10);
        blank(10);
        check("ovw_frames", 32'(n_frames - f0), 32'd1);
        check("ovw_digits", 32'(digits_out), 32'h3219);

        // reset mid-frame discards the partial mask
        drive(4'hE, 8'hC0, 10);
        drive(4'hD, 8'hF9, 10);
        an_in = 4'hF; seg_in = 8'hFF;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_digits", 32'(digits_out), 32'h0);
            check("midrst_flags", 32'({dp_out, err_out, frame_valid, frame_err}), 32'h0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        f0 = n_frames;
        drive(4'hB, 8'hA4, 10);
        drive(4'h7, 8'hB0, 10);
        blank(10);
        check("postrst_partial", 32'(n_frames - f0), 32'd0);
        drive(4'hE, 8'hC0, 10);
        drive(4'hD, 8'hF9, 10);
        blank(10);
        check("postrst_frames", 32'(n_frames - f0), 32'd1);
        check("postrst_digits", 32'(digits_out), 32'h3210);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) ran = 4'($urandom);
            else                           ran = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) rseg = {1'($urandom_range(0, 1)), tbl[$urandom_range(0, 9)]};
            else                          rseg = 8'($urandom);
            drive(ran, rseg, $urandom_range(1, 8));
            if (i == 200) begin
                #2 rst_n = 1'b0;
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
                @(negedge clk);
            end
        end
        blank(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
